alu_result_stage: RTL and testbench

Execute-to-writeback stage that sits directly downstream of the ALU. It captures each ALU result together with its NZCV flags and destination register, and evaluates the instruction's condition code against the architectural flag register. It commits flag updates in program order and buffers results in a 2-entry skid FIFO with a valid/ready handshake toward writeback. Throughput is one instruction per cycle; stalls in writeback do not lose data.

---
 rtl/alu_result_stage.sv | 123 ++++++++++++
 tb/tb_alu_result_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: condition check, in-order NZCV commit, 2-entry skid FIFO.
// Ports: in_* from ALU, out_* to writeback, out_flags = arch NZCV. Macro: ALU_STAGE_COND_EN.
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  input  logic             in_set_flags,
  input  logic [3:0]       in_cond,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wr_en,
  output logic             out_cond_pass,
  output logic [3:0]       out_flags
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             wr_en;
    logic             pass;
  } entry_t;

  entry_t     slot0;
  entry_t     slot1;
  entry_t     new_e;
  logic [1:0] count;
  logic [3:0] flags;
  logic       pass;
  logic       accept;
  logic       pop;

`ifdef ALU_STAGE_COND_EN
  logic n, z, c, v;
  always_comb begin
    {n, z, c, v} = flags;
    pass = 1'b0;
    case (in_cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c & !z;
      4'b1001: pass = !c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign pass = 1'b1;
`endif

  // in_ready only looks at registered count: no path from out_ready.
  assign in_ready = (count != 2'd2);
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = (count != 2'd0) && out_ready && !flush;

  always_comb begin
    new_e        = '0;
    new_e.result = in_result;
    new_e.rd     = in_rd;
    new_e.wr_en  = in_wr_en & pass;
    new_e.pass   = pass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
      flags <= 4'b0000;
    end else begin
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({accept, pop})
          2'b10: begin
            if (count == 2'd0) slot0 <= new_e;
            else               slot1 <= new_e;
            count <= count + 2'd1;
          end
          2'b01: begin
            slot0 <= slot1;
            count <= count - 2'd1;
          end
          // Only reachable at count 1: head leaves, new entry becomes head.
          2'b11: slot0 <= new_e;
          default: ;
        endcase
      end
      if (accept && in_set_flags && pass)
        flags <= in_flags;
    end
  end

  assign out_valid     = (count != 2'd0);
  assign out_result    = slot0.result;
  assign out_rd        = slot0.rd;
  assign out_wr_en     = slot0.wr_en;
  assign out_cond_pass = slot0.pass;
  assign out_flags     = flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps plus random traffic
// against a queue-based reference model.
module tb_alu_result_stage;

  logic       clk = 0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [3:0] in_flags;
  logic       in_set_flags;
  logic [3:0] in_cond;
  logic [3:0] in_rd;
  logic       in_wr_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_rd;
  logic       out_wr_en;
  logic       out_cond_pass;
  logic [3:0] out_flags;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] result;
    logic [3:0] rd;
    logic       we;
    logic       pass;
  } ent_t;

  ent_t       q[$];
  logic [3:0] mflags;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(4), .RD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .in_set_flags(in_set_flags), .in_cond(in_cond),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_cond_pass(out_cond_pass),
    .out_flags(out_flags)
  );

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
`ifdef ALU_STAGE_COND_EN
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    case (cc)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return c && !z;
      9: return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
`else
    return 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 8'(out_valid), 8'(q.size() != 0));
    chk("in_ready", 8'(in_ready), 8'(q.size() < 2));
    chk("out_flags", 8'(out_flags), 8'(mflags));
    if (q.size() != 0) begin
      chk("out_result", 8'(out_result), 8'(q[0].result));
      chk("out_rd", 8'(out_rd), 8'(q[0].rd));
      chk("out_wr_en", 8'(out_wr_en), 8'(q[0].we));
      chk("out_cond_pass", 8'(out_cond_pass), 8'(q[0].pass));
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] r, input logic [3:0] f,
                       input bit sf, input logic [3:0] cc, input logic [3:0] rd,
                       input bit we);
    in_valid = v; in_result = r; in_flags = f; in_set_flags = sf;
    in_cond = cc; in_rd = rd; in_wr_en = we;
  endtask

  // Predict one edge from the model, advance, then compare.
  task automatic cycle();
    bit   acc, pop, p;
    ent_t e;
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() != 0) && out_ready && !flush;
    p   = cond_ok(in_cond, mflags);
    e   = '{in_result, in_rd, in_wr_en && p, p};
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (acc && in_set_flags && p) mflags = in_flags;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 4'hE, 0, 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; out_ready = 0;
    idle();
    q.delete(); mflags = 0;
    #12;
    chk("rst_out_result", 8'(out_result), 0);
    chk("rst_out_rd", 8'(out_rd), 0);
    chk("rst_out_wr_en", 8'(out_wr_en), 0);
    chk("rst_out_cond_pass", 8'(out_cond_pass), 0);
    check_all();
    rst_n = 1;
    @(posedge clk); #1;

    // Flag update then EQ
    drive(1, 4'b0000, 4'b0100, 1, 4'hE, 0, 0); cycle();
    drive(1, 4'b1001, 4'b0000, 0, 4'h0, 3, 1); cycle();
    idle(); cycle();
    out_ready = 1; cycle(); cycle(); cycle();

    // Failed condition (NE after Z set)
    out_ready = 0;
    drive(1, 4'b0000, 4'b0100, 1, 4'hE, 0, 0); cycle();
    drive(1, 4'b1001, 4'b0000, 0, 4'h1, 3, 1); cycle();
    idle(); out_ready = 1; cycle(); cycle(); cycle();

    // Backpressure: three back-to-back, third held
    out_ready = 0;
    drive(1, 4'h1, 0, 0, 4'hE, 1, 1); cycle();
    drive(1, 4'h2, 0, 0, 4'hE, 2, 1); cycle();
    drive(1, 4'h3, 0, 0, 4'hE, 3, 1); cycle(); cycle();
    out_ready = 1; cycle();
    idle(); cycle(); cycle(); cycle();

    // Failed set_flags: V=1 then GE with set_flags
    drive(1, 0, 4'b0001, 1, 4'hE, 0, 0); cycle();
    drive(1, 5, 4'b1000, 1, 4'hA, 5, 1); cycle();
    idle(); cycle(); cycle();

    // Flush with full FIFO plus a valid input
    out_ready = 0;
    drive(1, 4'hA, 4'b0010, 1, 4'hE, 1, 1); cycle();
    drive(1, 4'hB, 0, 0, 4'hE, 2, 1); cycle();
    drive(1, 4'hC, 4'b1111, 1, 4'hE, 3, 1); flush = 1; out_ready = 1;
    cycle();
    flush = 0; idle(); cycle();

    // Reset mid-stream with two entries buffered
    out_ready = 0;
    drive(1, 4'h6, 4'b1010, 1, 4'hE, 6, 1); cycle();
    drive(1, 4'h7, 0, 0, 4'hE, 7, 1); cycle();
    idle();
    #2 rst_n = 0;
    #1;
    q.delete(); mflags = 0;
    check_all();
    #3 rst_n = 1;
    @(posedge clk); #1;
    check_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      cycle();
    end
    flush = 0; idle(); out_ready = 1; cycle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
